// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory stage of the 8-bit pipelined RISC core:
// default widths, access-counter width and the access FSM state type.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int ADDR_W_DFLT = 8;
    localparam int DEST_W_DFLT = 2;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage_data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Data memory array, 2**ADDR_W words of DATA_W bits. Synchronous write,
// asynchronous read. The array has no reset.
//
// Ports:
//   clk      in   clock, write occurs on the rising edge
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module data_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of the 8-bit pipelined RISC core. Takes the EXE/MEM register
// fields, performs loads/stores against a data memory with a MEM_LAT-cycle
// access time, stalls upstream while an access is in flight and drives the
// registered MEM/WB fields.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous reset, active low
//   WB_EN_in     in   write-back enable
//   MEM_R_EN_in  in   load request
//   MEM_W_EN_in  in   store request
//   Val_Ra_in    in   store data
//   ALU_Res_in   in   address for memory ops, ALU result otherwise
//   Dest_in      in   destination register
//   stall        out  combinational; upstream freezes while high
//   WB_EN        out  registered write-back enable
//   MEM_R_EN     out  registered; write-back selects Mem_Data when high
//   ALU_Res      out  registered ALU result
//   Mem_Data     out  registered load data
//   Dest         out  registered destination
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int ADDR_W  = ADDR_W_DFLT,
    parameter int DEST_W  = DEST_W_DFLT,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] Val_Ra_in,
    input  logic [DATA_W-1:0] ALU_Res_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              stall,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic [DATA_W-1:0] ALU_Res,
    output logic [DATA_W-1:0] Mem_Data,
    output logic [DEST_W-1:0] Dest
);

    localparam bit             MULTI    = (MEM_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Instruction captured at the start of a multi-cycle access.
    logic              hwb_q, hwb_d;
    logic              hmr_q, hmr_d;
    logic              hmw_q, hmw_d;
    logic [DATA_W-1:0] hval_q, hval_d;
    logic [DATA_W-1:0] halu_q, halu_d;
    logic [DEST_W-1:0] hdest_q, hdest_d;

    // MEM/WB output registers.
    logic              wb_q, wb_d;
    logic              mr_q, mr_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] md_q, md_d;
    logic [DEST_W-1:0] dest_q, dest_d;

    logic              is_mem;
    logic              we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign is_mem = MEM_R_EN_in | MEM_W_EN_in;

    // Upper ALU_Res bits are ignored, so addresses wrap modulo 2**ADDR_W.
    assign mem_addr = (state_q == BUSY) ? halu_q[ADDR_W-1:0] : ALU_Res_in[ADDR_W-1:0];

    assign stall = ((state_q == IDLE) && is_mem && MULTI) ||
                   ((state_q == BUSY) && (cnt_q > CNT_ONE));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hwb_d     = hwb_q;
        hmr_d     = hmr_q;
        hmw_d     = hmw_q;
        hval_d    = hval_q;
        halu_d    = halu_q;
        hdest_d   = hdest_q;
        wb_d      = 1'b0;
        mr_d      = 1'b0;
        alu_d     = '0;
        md_d      = '0;
        dest_d    = '0;
        we        = 1'b0;
        mem_wdata = Val_Ra_in;

        case (state_q)
            IDLE: begin
                if (!is_mem) begin
                    wb_d   = WB_EN_in;
                    mr_d   = MEM_R_EN_in;
                    alu_d  = ALU_Res_in;
                    dest_d = Dest_in;
                end else if (!MULTI) begin
                    // Single-cycle access: the read sees the pre-write value
                    // because the write lands on the same edge.
                    wb_d   = WB_EN_in;
                    mr_d   = MEM_R_EN_in;
                    alu_d  = ALU_Res_in;
                    md_d   = mem_rdata;
                    dest_d = Dest_in;
                    we     = MEM_W_EN_in;
                end else begin
                    hwb_d   = WB_EN_in;
                    hmr_d   = MEM_R_EN_in;
                    hmw_d   = MEM_W_EN_in;
                    hval_d  = Val_Ra_in;
                    halu_d  = ALU_Res_in;
                    hdest_d = Dest_in;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    wb_d      = hwb_q;
                    mr_d      = hmr_q;
                    alu_d     = halu_q;
                    md_d      = mem_rdata;
                    dest_d    = hdest_q;
                    we        = hmw_q;
                    mem_wdata = hval_q;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hwb_q   <= 1'b0;
            hmr_q   <= 1'b0;
            hmw_q   <= 1'b0;
            hval_q  <= '0;
            halu_q  <= '0;
            hdest_q <= '0;
            wb_q    <= 1'b0;
            mr_q    <= 1'b0;
            alu_q   <= '0;
            md_q    <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hwb_q   <= hwb_d;
            hmr_q   <= hmr_d;
            hmw_q   <= hmw_d;
            hval_q  <= hval_d;
            halu_q  <= halu_d;
            hdest_q <= hdest_d;
            wb_q    <= wb_d;
            mr_q    <= mr_d;
            alu_q   <= alu_d;
            md_q    <= md_d;
            dest_q  <= dest_d;
        end
    end

    // The memory itself has no reset, so the write is gated while reset is
    // held to keep an in-flight store from committing.
    data_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .we_i    (we & rst),
        .waddr_i (mem_addr),
        .wdata_i (mem_wdata),
        .raddr_i (mem_addr),
        .rdata_o (mem_rdata)
    );

    assign WB_EN    = wb_q;
    assign MEM_R_EN = mr_q;
    assign ALU_Res  = alu_q;
    assign Mem_Data = md_q;
    assign Dest     = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Three mem_stage instances (MEM_LAT = 1, 2, 4) share clock and reset. A
// reference memory per instance predicts each instruction's MEM/WB result
// and the cycle it must appear; a monitor pops expectations whenever an
// instance shows a non-bubble output.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int ND = 3;

    typedef struct {
        logic       wb;
        logic       mr;
        logic [7:0] alu;
        logic [7:0] md;
        logic [1:0] dest;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       wb_i   [ND];
    logic       mr_i   [ND];
    logic       mw_i   [ND];
    logic [7:0] val_i  [ND];
    logic [7:0] alu_i  [ND];
    logic [1:0] dest_i [ND];
    logic       stall_o[ND];
    logic       wb_o   [ND];
    logic       mr_o   [ND];
    logic [7:0] alu_o  [ND];
    logic [7:0] md_o   [ND];
    logic [1:0] dest_o [ND];

    logic [7:0] ref_mem [ND][256];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_stage #(.MEM_LAT(1)) u0 (
        .clk(clk), .rst(rst), .WB_EN_in(wb_i[0]), .MEM_R_EN_in(mr_i[0]), .MEM_W_EN_in(mw_i[0]),
        .Val_Ra_in(val_i[0]), .ALU_Res_in(alu_i[0]), .Dest_in(dest_i[0]), .stall(stall_o[0]),
        .WB_EN(wb_o[0]), .MEM_R_EN(mr_o[0]), .ALU_Res(alu_o[0]), .Mem_Data(md_o[0]), .Dest(dest_o[0]));
    mem_stage #(.MEM_LAT(2)) u1 (
        .clk(clk), .rst(rst), .WB_EN_in(wb_i[1]), .MEM_R_EN_in(mr_i[1]), .MEM_W_EN_in(mw_i[1]),
        .Val_Ra_in(val_i[1]), .ALU_Res_in(alu_i[1]), .Dest_in(dest_i[1]), .stall(stall_o[1]),
        .WB_EN(wb_o[1]), .MEM_R_EN(mr_o[1]), .ALU_Res(alu_o[1]), .Mem_Data(md_o[1]), .Dest(dest_o[1]));
    mem_stage #(.MEM_LAT(4)) u2 (
        .clk(clk), .rst(rst), .WB_EN_in(wb_i[2]), .MEM_R_EN_in(mr_i[2]), .MEM_W_EN_in(mw_i[2]),
        .Val_Ra_in(val_i[2]), .ALU_Res_in(alu_i[2]), .Dest_in(dest_i[2]), .stall(stall_o[2]),
        .WB_EN(wb_o[2]), .MEM_R_EN(mr_o[2]), .ALU_Res(alu_o[2]), .Mem_Data(md_o[2]), .Dest(dest_o[2]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int d, output exp_t e);
        case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    function automatic logic [19:0] out_vec(input int d);
        return {wb_o[d], mr_o[d], alu_o[d], md_o[d], dest_o[d]};
    endfunction

    // Monitor: every non-bubble output must match the oldest expectation,
    // including the cycle in which it appears.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < ND; d++) begin
                if (out_vec(d) != 20'd0) begin
                    if (qsize(d) == 0) begin
                        chk($sformatf("unexpected_out_u%0d", d), {12'(cyc), out_vec(d)}, 32'd0);
                    end else begin
                        exp_t e;
                        qpop(d, e);
                        chk($sformatf("out_u%0d", d), {12'(cyc), out_vec(d)},
                            {12'(e.cyc), e.wb, e.mr, e.alu, e.md, e.dest});
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input logic wb, input logic mr, input logic mw,
                         input logic [7:0] val, input logic [7:0] alu, input logic [1:0] dest);
        wb_i[d] = wb; mr_i[d] = mr; mw_i[d] = mw;
        val_i[d] = val; alu_i[d] = alu; dest_i[d] = dest;
    endtask

    task automatic chk_zero(input string nm, input int d);
        chk(nm, {11'd0, stall_o[d], out_vec(d)}, 32'd0);
    endtask

    // Called just after a falling edge with instance d idle. Presents one
    // instruction, checks stall through the access and returns at the
    // falling edge of the cycle after which the next instruction may go.
    task automatic issue(input int d, input logic wb, input logic mr, input logic mw,
                         input logic [7:0] val, input logic [7:0] alu, input logic [1:0] dest);
        int   lat;
        logic mem;
        exp_t e;
        mem = mr | mw;
        lat = mem ? lat_of(d) : 1;
        drive(d, wb, mr, mw, val, alu, dest);
        #1;
        chk($sformatf("stall_t0_u%0d", d), 32'(stall_o[d]), 32'(mem && lat > 1));
        e.wb = wb; e.mr = mr; e.alu = alu; e.dest = dest;
        e.md = mem ? ref_mem[d][alu] : 8'd0;
        e.cyc = cyc + lat;
        qpush(d, e);
        if (mw) ref_mem[d][alu] = val;
        @(negedge clk);
        for (int i = 1; i < lat; i++) begin
            if (i < lat - 1)
                drive(d, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
            else
                drive(d, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
            #1;
            chk($sformatf("stall_busy_u%0d", d), 32'(stall_o[d]), 32'(i < lat - 1));
            @(negedge clk);
        end
        drive(d, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
    endtask

    task automatic rand_run(input int d, input int n);
        logic [7:0] a;
        logic [7:0] alu;
        logic       wb;
        logic [1:0] dest;
        for (int j = 0; j < 8; j++)
            issue(d, 1'($urandom), 1'b0, 1'b1, 8'($urandom), 8'h40 + 8'(j), 2'($urandom));
        for (int j = 0; j < n; j++) begin
            a    = 8'h40 + 8'($urandom_range(0, 7));
            wb   = 1'($urandom);
            dest = 2'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    alu = 8'($urandom);
                    if ({wb, alu, dest} == 11'd0) wb = 1'b1;
                    issue(d, wb, 1'b0, 1'b0, 8'($urandom), alu, dest);
                end
                1: issue(d, wb, 1'b1, 1'b0, 8'($urandom), a, dest);
                2: issue(d, wb, 1'b0, 1'b1, 8'($urandom), a, dest);
                default: issue(d, wb, 1'b1, 1'b1, 8'($urandom), a, dest);
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < ND; d++) drive(d, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) chk_zero($sformatf("reset_u%0d", d), d);
        rst = 1'b1;
        @(negedge clk);

        // Pass-through, then store/load and read-modify-write on MEM_LAT=2.
        issue(1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 2'd2);
        issue(1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h10, 2'd0);
        issue(1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h10, 2'd3);
        chk("ref_store_load", 32'(ref_mem[1][8'h10]), 32'h0000_00A5);
        issue(1, 1'b0, 1'b0, 1'b1, 8'h11, 8'h20, 2'd1);
        issue(1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h20, 2'd1);
        issue(1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 2'd2);

        // Latency sweep on MEM_LAT=1 and MEM_LAT=4.
        issue(0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h50, 2'd1);
        issue(0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h50, 2'd2);
        issue(2, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h50, 2'd1);
        issue(2, 1'b1, 1'b1, 1'b0, 8'h00, 8'h50, 2'd2);

        for (int d = 0; d < ND; d++) rand_run(d, 40);

        // Reset in the second stall cycle of a MEM_LAT=4 store.
        issue(2, 1'b1, 1'b0, 1'b1, 8'h00, 8'h30, 2'd0);
        repeat (2) @(negedge clk);
        drive(2, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h30, 2'd1);
        #1;
        chk("rst_t0_stall", 32'(stall_o[2]), 32'd1);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0);
        #1;
        chk("rst_busy_stall", 32'(stall_o[2]), 32'd1);
        rst = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) chk_zero($sformatf("rst_async_u%0d", d), d);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) chk_zero($sformatf("rst_release_u%0d", d), d);
        repeat (6) @(negedge clk);
        issue(2, 1'b1, 1'b1, 1'b0, 8'h00, 8'h30, 2'd3);

        repeat (6) @(negedge clk);
        for (int d = 0; d < ND; d++) chk($sformatf("drain_u%0d", d), 32'(qsize(d)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 8-bit pipelined RISC core. It sits downstream of the EXE/MEM pipeline register and consumes its WB_EN, MEM_R_EN, MEM_W_EN, Val_Ra, ALU_Res and Dest outputs.
- Performs data-memory loads and stores with a configurable multi-cycle access latency, and stalls upstream stages while an access is in flight.
- Drives the registered MEM/WB fields consumed by write-back.

Parameters:
- DATA_W, 8, data and ALU result width.
- ADDR_W, 8, data-memory address width; depth = 2**ADDR_W; address = ALU_Res_in[ADDR_W-1:0].
- DEST_W, 2, destination register index width.
- MEM_LAT, 2, cycles per memory access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- WB_EN_in  in  1  write-back enable from EXE/MEM register.
- MEM_R_EN_in  in  1  load request.
- MEM_W_EN_in  in  1  store request.
- Val_Ra_in  in  DATA_W  store data.
- ALU_Res_in  in  DATA_W  memory address, or ALU result for non-memory ops.
- Dest_in  in  DEST_W  destination register.
- stall  out  1  combinational; upstream must freeze PC and pipeline registers while it is high.
- WB_EN  out  1  registered write-back enable.
- MEM_R_EN  out  1  registered; write-back selects Mem_Data when high, ALU_Res otherwise.
- ALU_Res  out  DATA_W  registered ALU result.
- Mem_Data  out  DATA_W  registered load data.
- Dest  out  DEST_W  registered destination.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE, counter=0, holding registers=0.
  - All registered outputs are 0; stall is 0.
  - Any pending store is discarded. Memory contents are not reset.
- FSM states: IDLE and BUSY.
- Non-memory op (MEM_R_EN_in=0 and MEM_W_EN_in=0) in IDLE:
  - Inputs register to outputs on the next edge (1-cycle latency).
  - Mem_Data loads 0; stall stays 0.
- Memory op in IDLE with MEM_LAT=1:
  - No stall.
  - On the next edge: a store writes mem[addr]=Val_Ra_in; the outputs register; Mem_Data = mem[addr] as read before the write.
- Memory op in IDLE with MEM_LAT>1 (presentation cycle t0):
  - stall=1 combinationally in t0.
  - At the edge ending t0: capture all inputs into holding registers, counter=MEM_LAT-1, go to BUSY, outputs load a bubble (all zero).
- In BUSY:
  - Inputs are ignored.
  - Each edge decrements counter, and outputs load a bubble every cycle before completion.
  - stall=1 while counter>1; stall=0 when counter==1 (the completion cycle).
  - At the edge where counter==1, using the held values: the store commits, Mem_Data = pre-write mem[addr], held WB_EN/MEM_R_EN/ALU_Res/Dest register to outputs, FSM returns to IDLE.
  - Net effect: stall is high for exactly MEM_LAT-1 cycles, and results are visible in cycle t0+MEM_LAT.
- Back-to-back: in the completion cycle, upstream presents the next instruction. It is evaluated in IDLE at the following edge, so there are no dead cycles beyond the MEM_LAT-1 stall.
- MEM_R_EN_in and MEM_W_EN_in both high:
  - Treated as read-modify-write: Mem_Data returns the old value and the store commits at completion.
  - Output MEM_R_EN follows MEM_R_EN_in.
- WB_EN is passed through unmodified. A store with WB_EN_in=1 still writes back ALU_Res.
- Address wraps modulo 2**ADDR_W. Upper ALU_Res bits above ADDR_W are ignored for addressing.
- Reset mid-BUSY: the store is not committed, no output pulse appears, and the FSM restarts in IDLE.
- A read of a never-written location returns X. Benches must write before reading.

Decomposition:
- Package mem_stage_pkg holds:
  - DATA_W, ADDR_W, DEST_W defaults.
  - State enum {IDLE, BUSY}.
  - CNT_W = 4.
- Sub-module data_mem: 2**ADDR_W x DATA_W array, synchronous write (we, waddr, wdata), asynchronous read (raddr -> rdata). It has no reset.

Test Plan:
- Reset: hold rst=0 mid-traffic, release at a clock edge -> all outputs 0, stall=0, FSM in IDLE.
- ALU pass-through, MEM_LAT=2: WB_EN_in=1, ALU_Res_in=8'h3C, Dest_in=2 -> next cycle WB_EN=1, ALU_Res=8'h3C, Dest=2, MEM_R_EN=0; stall never rises.
- Store then load, MEM_LAT=2: store Val_Ra_in=8'hA5 to addr 8'h10 -> stall high 1 cycle; then load addr 8'h10, Dest_in=3 -> stall high 1 cycle, then WB_EN=1, MEM_R_EN=1, Mem_Data=8'hA5, Dest=3 for one cycle.
- Latency sweep, MEM_LAT=1 and MEM_LAT=4: load from a preloaded address -> stall high 0 and 3 cycles respectively; exactly one non-bubble output per instruction.
- Read-modify-write: mem[8'h20]=8'h11, then R+W op with Val_Ra_in=8'h22 -> Mem_Data=8'h11; a later load of 8'h20 returns 8'h22.
- Reset mid-BUSY, MEM_LAT=4: store 8'hFF to 8'h30, assert rst in the second stall cycle -> stall drops immediately, no output pulse; after the store completes, mem[8'h30] keeps its prior value (8'h00, written beforehand).
